memory_bus_arbiter: RTL and testbench

- Merges NUM_MASTERS independent MemoryBus master ports onto one shared downstream memory slave port.
- Typical use: the ray tracer's memory port and the framebuffer/scan-out reader share one memory controller.
- Request path: round-robin arbitration into a single registered request slot.
- Response path: routed combinationally back to the owning master, decoded from the response ID.

---
 rtl/memory_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_memory_bus_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: merges NUM_MASTERS request ports onto one downstream
// port through a single registered request slot. Responses are routed back
// combinationally to the port that owns the response ID.
module memory_bus_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int DATA_WIDTH      = 24,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MASTER_ID_WIDTH = 8,
  parameter int IDS_PER_MASTER  = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_MASTERS*MASTER_ID_WIDTH-1:0] umsID,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0]   umsAddress,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      umsData,
  input  logic [NUM_MASTERS-1:0]                 umsWrite,
  input  logic [NUM_MASTERS-1:0]                 umsValid,
  output logic [NUM_MASTERS-1:0]                 umsTaken,
  output logic [NUM_MASTERS*MASTER_ID_WIDTH-1:0] usmID,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]      usmData,
  output logic [NUM_MASTERS-1:0]                 usmValid,
  input  logic [NUM_MASTERS-1:0]                 usmTaken,
  output logic [MASTER_ID_WIDTH-1:0]             dmsID,
  output logic [ADDRESS_WIDTH-1:0]               dmsAddress,
  output logic [DATA_WIDTH-1:0]                  dmsData,
  output logic                                   dmsWrite,
  output logic                                   dmsValid,
  input  logic                                   dmsTaken,
  input  logic [MASTER_ID_WIDTH-1:0]             dsmID,
  input  logic [DATA_WIDTH-1:0]                  dsmData,
  input  logic                                   dsmValid,
  output logic                                   dsmTaken,
  output logic                                   idError
);

  localparam int PW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int ISH = (IDS_PER_MASTER > 1) ? $clog2(IDS_PER_MASTER) : 0;

  logic          full;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] grant_idx;
  logic [PW:0]   grant_inc;
  logic          any_valid;
  logic          load;
  logic          grant;
  int            scan_idx;

  logic [MASTER_ID_WIDTH-1:0] owner;
  logic [PW-1:0]              owner_idx;
  logic                       owner_ok;

  // Round-robin scan starting at ptr; lowest offset with a valid request wins.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NUM_MASTERS) scan_idx = scan_idx - NUM_MASTERS;
      if (umsValid[scan_idx]) begin
        any_valid = 1'b1;
        grant_idx = PW'(scan_idx);
      end
    end
  end

  // Accept a new request whenever the slot is empty or being drained this cycle.
  always_comb begin
    load      = !full || dmsTaken;
    grant     = load && any_valid;
    umsTaken  = grant ? (NUM_MASTERS'(1) << grant_idx) : '0;
    grant_inc = {1'b0, grant_idx} + 1'b1;
    ptr_next  = (grant_inc == (PW + 1)'(NUM_MASTERS)) ? '0 : grant_inc[PW-1:0];
  end

  // Slot occupancy, round-robin pointer and sticky ID error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      full    <= 1'b0;
      ptr     <= '0;
      idError <= 1'b0;
    end else begin
      if (grant) begin
        full <= 1'b1;
        ptr  <= ptr_next;
      end else if (dmsTaken) begin
        full <= 1'b0;
      end
      if (dsmValid && !owner_ok) idError <= 1'b1;
    end
  end

  // Request payload captured from the winning port; only meaningful while full.
  always_ff @(posedge clock) begin
    if (grant) begin
      dmsID      <= umsID[grant_idx*MASTER_ID_WIDTH +: MASTER_ID_WIDTH];
      dmsAddress <= umsAddress[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      dmsData    <= umsData[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      dmsWrite   <= umsWrite[grant_idx];
    end
  end

  assign dmsValid = full;

  // Response routing: the owning port is the ID divided by IDS_PER_MASTER.
  // Responses with an unowned ID are accepted and dropped.
  always_comb begin
    owner     = dsmID >> ISH;
    owner_ok  = (owner < MASTER_ID_WIDTH'(NUM_MASTERS));
    owner_idx = owner[PW-1:0];
    usmValid  = '0;
    dsmTaken  = 1'b1;
    if (owner_ok) begin
      usmValid[owner_idx] = dsmValid;
      dsmTaken            = usmTaken[owner_idx];
    end
  end

  assign usmID   = {NUM_MASTERS{dsmID}};
  assign usmData = {NUM_MASTERS{dsmData}};

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter with two ports and default widths.
module tb_memory_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] umsID;
  logic [63:0] umsAddress;
  logic [47:0] umsData;
  logic [1:0]  umsWrite;
  logic [1:0]  umsValid;
  logic [1:0]  umsTaken;
  logic [15:0] usmID;
  logic [47:0] usmData;
  logic [1:0]  usmValid;
  logic [1:0]  usmTaken;
  logic [7:0]  dmsID;
  logic [31:0] dmsAddress;
  logic [23:0] dmsData;
  logic        dmsWrite;
  logic        dmsValid;
  logic        dmsTaken;
  logic [7:0]  dsmID;
  logic [23:0] dsmData;
  logic        dsmValid;
  logic        dsmTaken;
  logic        idError;

  int errors = 0;
  int checks = 0;

  memory_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .umsID(umsID), .umsAddress(umsAddress), .umsData(umsData),
    .umsWrite(umsWrite), .umsValid(umsValid), .umsTaken(umsTaken),
    .usmID(usmID), .usmData(usmData), .usmValid(usmValid), .usmTaken(usmTaken),
    .dmsID(dmsID), .dmsAddress(dmsAddress), .dmsData(dmsData),
    .dmsWrite(dmsWrite), .dmsValid(dmsValid), .dmsTaken(dmsTaken),
    .dsmID(dsmID), .dsmData(dsmData), .dsmValid(dsmValid), .dsmTaken(dsmTaken),
    .idError(idError)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    umsID      = '0;
    umsAddress = '0;
    umsData    = '0;
    umsWrite   = '0;
    umsValid   = '0;
    usmTaken   = '0;
    dmsTaken   = 1'b0;
    dsmID      = '0;
    dsmData    = '0;
    dsmValid   = 1'b0;
    tick();
    tick();
    check("reset_dmsValid", 64'(dmsValid), 64'd0);
    check("reset_umsTaken", 64'(umsTaken), 64'd0);
    check("reset_idError", 64'(idError), 64'd0);
    reset = 1'b0;

    // Single request from port 1.
    umsID      = {8'h05, 8'h00};
    umsAddress = {32'h26, 32'h0};
    umsData    = {24'h123456, 24'h0};
    umsWrite   = 2'b00;
    umsValid   = 2'b10;
    dmsTaken   = 1'b1;
    #1;
    check("single_taken", 64'(umsTaken), 64'h2);
    tick();
    umsValid = 2'b00;
    check("single_dmsValid", 64'(dmsValid), 64'd1);
    check("single_dmsID", 64'(dmsID), 64'h05);
    check("single_dmsAddress", 64'(dmsAddress), 64'h26);
    check("single_dmsData", 64'(dmsData), 64'h123456);
    check("single_dmsWrite", 64'(dmsWrite), 64'd0);
    tick();
    check("single_drained", 64'(dmsValid), 64'd0);

    // Contention: both ports valid, downstream always takes.
    umsID      = {8'h04, 8'h01};
    umsAddress = {32'h200, 32'h100};
    umsData    = {24'hBBBBBB, 24'hAAAAAA};
    umsWrite   = 2'b01;
    umsValid   = 2'b11;
    #1;
    check("cont_taken0", 64'(umsTaken), 64'h1);
    tick();
    check("cont_id0", 64'(dmsID), 64'h01);
    check("cont_wr0", 64'(dmsWrite), 64'd1);
    check("cont_taken1", 64'(umsTaken), 64'h2);
    tick();
    check("cont_id1", 64'(dmsID), 64'h04);
    check("cont_valid1", 64'(dmsValid), 64'd1);
    check("cont_taken2", 64'(umsTaken), 64'h1);
    tick();
    check("cont_id2", 64'(dmsID), 64'h01);
    check("cont_taken3", 64'(umsTaken), 64'h2);
    tick();
    check("cont_id3", 64'(dmsID), 64'h04);
    check("cont_addr3", 64'(dmsAddress), 64'h200);
    check("cont_valid3", 64'(dmsValid), 64'd1);

    // Backpressure: slot holds port 1's request for 3 cycles.
    dmsTaken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_taken", 64'(umsTaken), 64'd0);
      tick();
      check("bp_valid", 64'(dmsValid), 64'd1);
      check("bp_id", 64'(dmsID), 64'h04);
      check("bp_addr", 64'(dmsAddress), 64'h200);
      check("bp_data", 64'(dmsData), 64'hBBBBBB);
    end
    dmsTaken = 1'b1;
    #1;
    check("bp_release_taken", 64'(umsTaken), 64'h1);
    tick();
    check("bp_release_id", 64'(dmsID), 64'h01);
    umsValid = 2'b00;
    tick();
    check("bp_drained", 64'(dmsValid), 64'd0);

    // Response routing to port 1.
    dsmID    = 8'h06;
    dsmData  = 24'hABCDEF;
    dsmValid = 1'b1;
    usmTaken = 2'b00;
    #1;
    check("rsp_usmValid", 64'(usmValid), 64'h2);
    check("rsp_dsmTaken_low0", 64'(dsmTaken), 64'd0);
    check("rsp_usmID", 64'(usmID[15:8]), 64'h06);
    check("rsp_usmData", 64'(usmData[47:24]), 64'hABCDEF);
    tick();
    check("rsp_dsmTaken_low1", 64'(dsmTaken), 64'd0);
    check("rsp_usmValid_held", 64'(usmValid), 64'h2);
    usmTaken = 2'b01;
    #1;
    check("rsp_wrong_port_taken", 64'(dsmTaken), 64'd0);
    usmTaken = 2'b10;
    #1;
    check("rsp_dsmTaken_high", 64'(dsmTaken), 64'd1);
    tick();
    dsmID    = 8'h03;
    usmTaken = 2'b01;
    #1;
    check("rsp_port0_valid", 64'(usmValid), 64'h1);
    check("rsp_port0_taken", 64'(dsmTaken), 64'd1);
    tick();

    // Unowned ID 0x09.
    dsmID    = 8'h09;
    usmTaken = 2'b00;
    #1;
    check("bad_usmValid", 64'(usmValid), 64'd0);
    check("bad_dsmTaken", 64'(dsmTaken), 64'd1);
    check("bad_idError_before", 64'(idError), 64'd0);
    tick();
    dsmValid = 1'b0;
    check("bad_idError_set", 64'(idError), 64'd1);
    tick();
    check("bad_idError_sticky", 64'(idError), 64'd1);

    // Reset while the slot is stalled; pointer is at port 1 beforehand.
    umsValid = 2'b01;
    dmsTaken = 1'b1;
    tick();
    umsValid = 2'b00;
    dmsTaken = 1'b0;
    tick();
    check("stall_full", 64'(dmsValid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_dmsValid", 64'(dmsValid), 64'd0);
    check("rst_idError", 64'(idError), 64'd0);
    umsValid = 2'b11;
    dmsTaken = 1'b1;
    #1;
    check("rst_first_grant", 64'(umsTaken), 64'h1);
    tick();
    check("rst_first_id", 64'(dmsID), 64'h01);
    umsValid = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
